vga_tile_timing: RTL

VGA_TILE_TIMING -- requirements
Module: vga_tile_timing

---
 rtl/vga_timing_pkg.sv | 48 ++++
 rtl/wrap_counter.sv | 33 +++
 rtl/vga_tile_timing.sv | 117 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, output bundle type and tile-index helper.
// Defaults describe 640x480 at 60 Hz; tiles use a 6-bit index with 63 as off-screen.
package vga_timing_pkg;

  localparam int unsigned HActive = 640;
  localparam int unsigned HFp     = 16;
  localparam int unsigned HSync   = 96;
  localparam int unsigned HBp     = 48;
  localparam int unsigned VActive = 480;
  localparam int unsigned VFp     = 10;
  localparam int unsigned VSync   = 2;
  localparam int unsigned VBp     = 33;
  localparam int unsigned HTotal  = HActive + HFp + HSync + HBp;
  localparam int unsigned VTotal  = VActive + VFp + VSync + VBp;

  localparam int unsigned CntW  = 10;
  localparam int unsigned TileW = 6;
  localparam logic [TileW-1:0] TileOff = 6'd63;

  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic             active;
    logic [CntW-1:0]  pixel_x;
    logic [CntW-1:0]  pixel_y;
    logic [TileW-1:0] counter_x;
    logic [TileW-1:0] counter_y;
    logic             line_start;
    logic             frame_start;
  } vga_out_t;

  localparam vga_out_t OutRst = '{
    hsync: 1'b1, vsync: 1'b1, active: 1'b0,
    pixel_x: '0, pixel_y: '0,
    counter_x: TileOff, counter_y: TileOff,
    line_start: 1'b0, frame_start: 1'b0
  };

  // Off-screen positions map to the sentinel so no drawer ever matches them.
  function automatic logic [TileW-1:0] tile_idx(input logic [CntW-1:0] pos,
                                                input int unsigned  shift,
                                                input int unsigned  limit);
    logic [CntW-1:0] sh;
    sh = pos >> shift;
    return (pos < CntW'(limit)) ? sh[TileW-1:0] : TileOff;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N up counter advancing on en_i; wrap_o flags the enabled step from N-1 back to 0.
module wrap_counter #(
  parameter int unsigned Modulus = 800,
  parameter int unsigned Width   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [Width-1:0] count_o,
  output logic             wrap_o
);

  logic [Width-1:0] count_q, count_d;

  assign wrap_o  = en_i && (count_q == Width'(Modulus - 1));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_tile_timing.sv
// VGA raster timing with pixel-clock prescaler and tile coordinates for a block drawer.
// All outputs are registered on the prescaler tick so they stay aligned with pix_en.
module vga_tile_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = HActive,
  parameter int unsigned H_FP       = HFp,
  parameter int unsigned H_SYNC     = HSync,
  parameter int unsigned H_BP       = HBp,
  parameter int unsigned V_ACTIVE   = VActive,
  parameter int unsigned V_FP       = VFp,
  parameter int unsigned V_SYNC     = VSync,
  parameter int unsigned V_BP       = VBp,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned TILE_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic [CntW-1:0]  pixel_x,
  output logic [CntW-1:0]  pixel_y,
  output logic [TileW-1:0] counter_x,
  output logic [TileW-1:0] counter_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HSyncLo = H_ACTIVE + H_FP;
  localparam int unsigned HSyncHi = HSyncLo + H_SYNC;
  localparam int unsigned VSyncLo = V_ACTIVE + V_FP;
  localparam int unsigned VSyncHi = VSyncLo + V_SYNC;
  localparam int unsigned PresW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(CLK_DIV - 1);

  logic [PresW-1:0] presc_q, presc_d;
  logic             pix_en_q, pix_en_d;
  logic             tick;
  logic [CntW-1:0]  h_cnt, v_cnt;
  logic             h_wrap, v_wrap;
  logic             unused_v_wrap;
  vga_out_t         out_q, out_d;

  assign tick     = (presc_q == PresMax);
  assign presc_d  = tick ? '0 : presc_q + PresW'(1);
  assign pix_en_d = tick;
  assign unused_v_wrap = v_wrap;

  // The counters hold the pixel about to be shown; the tick edge both registers
  // that pixel onto the outputs and steps the counters to the next one.
  wrap_counter #(
    .Modulus(H_TOTAL),
    .Width  (CntW)
  ) u_h_cnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (tick),
    .count_o(h_cnt),
    .wrap_o (h_wrap)
  );

  wrap_counter #(
    .Modulus(V_TOTAL),
    .Width  (CntW)
  ) u_v_cnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (h_wrap),
    .count_o(v_cnt),
    .wrap_o (v_wrap)
  );

  always_comb begin
    out_d = out_q;
    out_d.line_start  = 1'b0;
    out_d.frame_start = 1'b0;
    if (tick) begin
      out_d.hsync       = !((h_cnt >= CntW'(HSyncLo)) && (h_cnt < CntW'(HSyncHi)));
      out_d.vsync       = !((v_cnt >= CntW'(VSyncLo)) && (v_cnt < CntW'(VSyncHi)));
      out_d.active      = (h_cnt < CntW'(H_ACTIVE)) && (v_cnt < CntW'(V_ACTIVE));
      out_d.pixel_x     = h_cnt;
      out_d.pixel_y     = v_cnt;
      out_d.counter_x   = tile_idx(h_cnt, TILE_SHIFT, H_ACTIVE);
      out_d.counter_y   = tile_idx(v_cnt, TILE_SHIFT, V_ACTIVE);
      out_d.line_start  = (h_cnt == '0);
      out_d.frame_start = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      pix_en_q <= 1'b0;
      out_q    <= OutRst;
    end else begin
      presc_q  <= presc_d;
      pix_en_q <= pix_en_d;
      out_q    <= out_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign hsync       = out_q.hsync;
  assign vsync       = out_q.vsync;
  assign active      = out_q.active;
  assign pixel_x     = out_q.pixel_x;
  assign pixel_y     = out_q.pixel_y;
  assign counter_x   = out_q.counter_x;
  assign counter_y   = out_q.counter_y;
  assign line_start  = out_q.line_start;
  assign frame_start = out_q.frame_start;

endmodule
